// File: rtl/step_bounce_counter.sv
// Parametrised up/down step counter bounded to [LO, HI] with up-wrap, down-wrap,
// bounce (triangle) and hold modes, parallel load and a run-time step register.
module step_bounce_counter #(
    parameter int WIDTH    = 8,
    parameter int LO       = 7,
    parameter int HI       = 210,
    parameter int STEP_RST = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_dir,
    input  logic             step_wr,
    input  logic [WIDTH-1:0] step_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             at_hi,
    output logic             at_lo
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DN     = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] LO_W       = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_W       = WIDTH'(HI);
    localparam logic [WIDTH:0]   LO_X       = (WIDTH+1)'(LO);
    localparam logic [WIDTH:0]   HI_X       = (WIDTH+1)'(HI);
    localparam logic [WIDTH-1:0] STEP_RST_W = WIDTH'(STEP_RST);
    localparam logic [WIDTH-1:0] ZERO_W     = WIDTH'(0);

    logic [WIDTH-1:0] count_r;
    logic             dir_r;
    logic             tc_r;
    logic [WIDTH-1:0] step_r;

    logic [WIDTH-1:0] count_s;
    logic             dir_s;
    logic             tc_s;
    logic [WIDTH:0]   up_s;
    logic [WIDTH:0]   dn_s;
    logic             up_ok_s;
    logic             dn_ok_s;
    logic             step_zero_s;
    mode_t            mode_s;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v < LO_W) begin
            r = LO_W;
        end else if (v > HI_W) begin
            r = HI_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // One extra bit keeps the carry of up and the borrow of dn visible.
    assign up_s        = {1'b0, count_r} + {1'b0, step_r};
    assign dn_s        = {1'b0, count_r} - {1'b0, step_r};
    assign up_ok_s     = (up_s <= HI_X);
    assign dn_ok_s     = ~dn_s[WIDTH] & (dn_s >= LO_X);
    assign step_zero_s = (step_r == ZERO_W);
    assign mode_s      = mode_t'(mode);

    // Next-state selection: load beats counting; a zero step never moves or pulses.
    always_comb begin
        count_s = count_r;
        dir_s   = dir_r;
        tc_s    = 1'b0;
        if (load) begin
            count_s = clamp_load(load_val);
            dir_s   = load_dir;
        end else if (en) begin
            case (mode_s)
                MODE_UP: begin
                    dir_s = 1'b1;
                    if (step_zero_s) begin
                        count_s = count_r;
                    end else if (up_ok_s) begin
                        count_s = up_s[WIDTH-1:0];
                    end else begin
                        count_s = LO_W;
                        tc_s    = 1'b1;
                    end
                end
                MODE_DN: begin
                    dir_s = 1'b0;
                    if (step_zero_s) begin
                        count_s = count_r;
                    end else if (dn_ok_s) begin
                        count_s = dn_s[WIDTH-1:0];
                    end else begin
                        count_s = HI_W;
                        tc_s    = 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    if (step_zero_s) begin
                        count_s = count_r;
                    end else if (dir_r) begin
                        if (up_ok_s) begin
                            count_s = up_s[WIDTH-1:0];
                        end else begin
                            dir_s   = 1'b0;
                            count_s = dn_ok_s ? dn_s[WIDTH-1:0] : LO_W;
                            tc_s    = 1'b1;
                        end
                    end else begin
                        if (dn_ok_s) begin
                            count_s = dn_s[WIDTH-1:0];
                        end else begin
                            dir_s   = 1'b1;
                            count_s = up_ok_s ? up_s[WIDTH-1:0] : HI_W;
                            tc_s    = 1'b1;
                        end
                    end
                end
                MODE_HOLD: begin
                    count_s = count_r;
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end else begin
            count_s = count_r;
        end
    end

    // State registers with synchronous reset; step_wr is outside the load/count priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= LO_W;
            dir_r   <= 1'b1;
            tc_r    <= 1'b0;
            step_r  <= STEP_RST_W;
        end else begin
            count_r <= count_s;
            dir_r   <= dir_s;
            tc_r    <= tc_s;
            if (step_wr) begin
                step_r <= step_val;
            end
        end
    end

    assign count = count_r;
    assign dir   = dir_r;
    assign tc    = tc_r;
    assign at_hi = (count_r == HI_W);
    assign at_lo = (count_r == LO_W);

endmodule

// File: tb/tb_step_bounce_counter.sv
// Scoreboard bench for step_bounce_counter at default parameters (8 bits, 7..210, step 7).
module tb_step_bounce_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       load_dir = 1'b0;
    logic       step_wr = 1'b0;
    logic [7:0] step_val = 8'd0;
    logic [7:0] count;
    logic       dir;
    logic       tc;
    logic       at_hi;
    logic       at_lo;

    typedef struct {
        logic [7:0] count;
        logic       dir;
        logic       tc;
        bit         care_dir;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    step_bounce_counter #(
        .WIDTH(8), .LO(7), .HI(210), .STEP_RST(7)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .load_dir(load_dir), .step_wr(step_wr),
        .step_val(step_val), .count(count), .dir(dir), .tc(tc),
        .at_hi(at_hi), .at_lo(at_lo)
    );

    // Drive one clock's inputs on the falling edge and queue the post-edge expectation.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m, input logic l,
                       input logic [7:0] lv, input logic ld, input logic sw, input logic [7:0] sv,
                       input logic [7:0] c, input logic d, input logic t, input bit cd,
                       input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; load = l; load_val = lv; load_dir = ld;
        step_wr = sw; step_val = sv;
        x.count = c; x.dir = d; x.tc = t; x.care_dir = cd; x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic run(input logic e, input logic [1:0] m, input logic [7:0] c,
                       input logic d, input logic t, input string nm);
        cyc(1'b0, e, m, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, c, d, t, 1'b1, nm);
    endtask

    task automatic ldv(input logic e, input logic [1:0] m, input logic [7:0] lv,
                       input logic ldir, input logic [7:0] c, input logic d, input string nm);
        cyc(1'b0, e, m, 1'b1, lv, ldir, 1'b0, 8'd0, c, d, 1'b0, 1'b1, nm);
    endtask

    // Monitor: one expectation per clock, checked just after the rising edge.
    initial begin
        exp_t mx;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                mx = exp_q.pop_front();
                n_vec++;
                ok = (count === mx.count) && (tc === mx.tc) &&
                     (at_hi === (mx.count == 8'd210)) && (at_lo === (mx.count == 8'd7)) &&
                     (!mx.care_dir || (dir === mx.dir));
                if (!ok) begin
                    n_err++;
                    $display("FAIL %s: got count=%0d dir=%b tc=%b at_hi=%b at_lo=%b, want count=%0d dir=%b(care=%0b) tc=%b",
                             mx.name, count, dir, tc, at_hi, at_lo, mx.count, mx.dir, mx.care_dir, mx.tc);
                end
            end
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd7, 1'b1, 1'b0, 1'b1, "reset");
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd7, 1'b1, 1'b0, 1'b1, "reset2");

        // Full triangle: 29 steps up, bounce at 210 to 203, down to 7, bounce to 14.
        for (int i = 1; i <= 60; i++) begin
            if (i <= 29)      run(1'b1, 2'b10, 8'(7 + 7 * i), 1'b1, 1'b0, "bounce_up");
            else if (i == 30) run(1'b1, 2'b10, 8'd203, 1'b0, 1'b1, "bounce_top");
            else if (i <= 58) run(1'b1, 2'b10, 8'(203 - 7 * (i - 30)), 1'b0, 1'b0, "bounce_dn");
            else if (i == 59) run(1'b1, 2'b10, 8'd14, 1'b1, 1'b1, "bounce_bot");
            else              run(1'b1, 2'b10, 8'd21, 1'b1, 1'b0, "bounce_resume");
        end

        ldv(1'b1, 2'b00, 8'd203, 1'b0, 8'd203, 1'b0, "load_beats_en");
        run(1'b1, 2'b00, 8'd210, 1'b1, 1'b0, "upwrap_210");
        run(1'b1, 2'b00, 8'd7,   1'b1, 1'b1, "upwrap_wrap");
        run(1'b1, 2'b00, 8'd14,  1'b1, 1'b0, "upwrap_14");

        ldv(1'b1, 2'b01, 8'd14, 1'b1, 8'd14, 1'b1, "load_14");
        run(1'b1, 2'b01, 8'd7,   1'b0, 1'b0, "dnwrap_7");
        run(1'b1, 2'b01, 8'd210, 1'b0, 1'b1, "dnwrap_wrap");
        run(1'b1, 2'b01, 8'd203, 1'b0, 1'b0, "dnwrap_203");

        cyc(1'b0, 1'b0, 2'b10, 1'b0, 8'd0, 1'b0, 1'b1, 8'd250, 8'd203, 1'b0, 1'b0, 1'b1, "stepwr_250");
        ldv(1'b1, 2'b10, 8'd200, 1'b1, 8'd200, 1'b1, "load_200");
        run(1'b1, 2'b10, 8'd7,   1'b0, 1'b1, "bigstep_top");
        run(1'b1, 2'b10, 8'd210, 1'b1, 1'b1, "bigstep_bot");

        cyc(1'b0, 1'b0, 2'b10, 1'b1, 8'd3, 1'b1, 1'b1, 8'd7, 8'd7, 1'b1, 1'b0, 1'b1, "clamp_lo");
        ldv(1'b0, 2'b10, 8'd255, 1'b0, 8'd210, 1'b0, "clamp_hi");

        cyc(1'b1, 1'b1, 2'b00, 1'b1, 8'd100, 1'b0, 1'b0, 8'd0, 8'd7, 1'b1, 1'b0, 1'b1, "rst_load_en");

        run(1'b1, 2'b10, 8'd14, 1'b1, 1'b0, "ramp_14");
        run(1'b1, 2'b10, 8'd21, 1'b1, 1'b0, "ramp_21");
        run(1'b1, 2'b10, 8'd28, 1'b1, 1'b0, "ramp_28");
        for (int i = 0; i < 4; i++) run(1'b0, 2'b10, 8'd28, 1'b1, 1'b0, "en_low");
        run(1'b0, 2'b00, 8'd28, 1'b1, 1'b0, "en_low_mode0");

        // The writing edge still uses step 7; afterwards nothing moves in any mode.
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 8'd35, 1'b1, 1'b0, 1'b1, "stepwr_0");
        for (int m = 0; m < 4; m++)
            cyc(1'b0, 1'b1, 2'(m), 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd35, 1'b0, 1'b0, 1'b0, "step0_mid");
        ldv(1'b0, 2'b00, 8'd210, 1'b1, 8'd210, 1'b1, "load_210");
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd210, 1'b0, 1'b0, 1'b0, "step0_hi_up");
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd210, 1'b0, 1'b0, 1'b0, "step0_hi_bn");
        ldv(1'b0, 2'b01, 8'd7, 1'b0, 8'd7, 1'b0, "load_7");
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd7, 1'b0, 1'b0, 1'b0, "step0_lo_dn");
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd7, 1'b0, 1'b0, 1'b0, "step0_lo_bn");
        cyc(1'b0, 1'b0, 2'b10, 1'b0, 8'd0, 1'b0, 1'b1, 8'd7, 8'd7, 1'b0, 1'b0, 1'b0, "stepwr_7");

        ldv(1'b0, 2'b10, 8'd49, 1'b1, 8'd49, 1'b1, "load_49");
        run(1'b1, 2'b10, 8'd56, 1'b1, 1'b0, "sw_up_56");
        run(1'b1, 2'b10, 8'd63, 1'b1, 1'b0, "sw_up_63");
        run(1'b1, 2'b11, 8'd63, 1'b1, 1'b0, "sw_hold1");
        run(1'b1, 2'b11, 8'd63, 1'b1, 1'b0, "sw_hold2");
        run(1'b1, 2'b10, 8'd70, 1'b1, 1'b0, "sw_resume_up");
        ldv(1'b0, 2'b10, 8'd100, 1'b0, 8'd100, 1'b0, "load_100");
        run(1'b1, 2'b10, 8'd93, 1'b0, 1'b0, "sw_dn_93");
        run(1'b1, 2'b11, 8'd93, 1'b0, 1'b0, "sw_dn_hold");
        run(1'b1, 2'b10, 8'd86, 1'b0, 1'b0, "sw_resume_dn");
        run(1'b1, 2'b00, 8'd93, 1'b1, 1'b0, "sw_to_up");
        run(1'b1, 2'b10, 8'd100, 1'b1, 1'b0, "sw_up_keeps_dir");

        cyc(1'b1, 1'b1, 2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd7, 1'b1, 1'b0, 1'b1, "rst_mid_ramp");
        run(1'b1, 2'b10, 8'd14, 1'b1, 1'b0, "after_rst");

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
